// File: rtl/mlp_mac_argmax_if.sv
// Beat input, score output and run-status bundle for the two-layer MAC/argmax stage.
// The master side feeds tagged beats; the slave side (the datapath) reports scores and status.
`timescale 1ns/1ps
interface mlp_mac_argmax_if #(
  parameter int DW = 8,
  parameter int OW = 36
);
  logic                 start;
  logic                 in_valid;
  logic [3:0]           q_idx;
  logic [7:0]           n_idx;
  logic [3:0]           i_idx;
  logic signed [DW-1:0] x_in;
  logic signed [DW-1:0] w1_in;
  logic signed [DW-1:0] w2_in;
  logic                 score_valid;
  logic [3:0]           score_idx;
  logic signed [OW-1:0] score;
  logic [3:0]           class_idx;
  logic signed [OW-1:0] class_score;
  logic                 done;
  logic                 busy;
  logic                 err;

  modport master (
    output start, in_valid, q_idx, n_idx, i_idx, x_in, w1_in, w2_in,
    input  score_valid, score_idx, score, class_idx, class_score, done, busy, err
  );

  modport slave (
    input  start, in_valid, q_idx, n_idx, i_idx, x_in, w1_in, w2_in,
    output score_valid, score_idx, score, class_idx, class_score, done, busy, err
  );
endinterface

// File: rtl/mlp_mac_argmax.sv
// Two-layer MLP datapath: per output class, ReLU hidden sums weighted into a score,
// followed by a running argmax over the emitted scores.
//
// state  | meaning
// S_IDLE | after reset, waiting for start; beats ignored
// S_RUN  | accepting in-order beats, pipeline active (busy)
// S_DONE | all scores emitted, class result held (done)
`timescale 1ns/1ps
module mlp_mac_argmax #(
  parameter int DW = 8,
  parameter int NQ = 8,
  parameter int NN = 200,
  parameter int NI = 10,
  parameter int OW = 36
) (
  input  logic            clk,
  input  logic            rst,
  mlp_mac_argmax_if.slave bus
);
  localparam int PW = 2 * DW;
  localparam int HW = 2 * DW + 4;
  localparam logic [3:0] Q_LAST = 4'(NQ);
  localparam logic [7:0] N_LAST = 8'(NN);
  localparam logic [3:0] I_LAST = 4'(NI);

  typedef enum logic [1:0] {S_IDLE, S_RUN, S_DONE} state_t;
  state_t state, state_nx;

  logic [3:0] exp_q, exp_i;
  logic [7:0] exp_n;
  logic       beat_live, tuple_ok, accept;
  logic       err_r;

  logic                 v1, q_first1, q_last1, n_first1, n_last1;
  logic [3:0]           i1;
  logic signed [PW-1:0] p1;
  logic signed [DW-1:0] w2_1;

  logic                 v2, n_first2, n_last2;
  logic [3:0]           i2;
  logic signed [HW-1:0] hacc, h_sum, h_relu, h2;
  logic signed [DW-1:0] w2_2;

  logic                 v3;
  logic [3:0]           i3;
  logic signed [OW-1:0] sacc, prod2;

  logic                 sv_r;
  logic [3:0]           sidx_r;
  logic signed [OW-1:0] score_r;
  logic [3:0]           max_idx;
  logic signed [OW-1:0] max_score;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) state <= S_IDLE;
    else      state <= state_nx;
  end

  always_comb begin
    state_nx = state;
    if (bus.start)
      state_nx = S_RUN;
    else if (state == S_RUN && sv_r && sidx_r == I_LAST)
      state_nx = S_DONE;
  end

  assign bus.busy = (state == S_RUN);
  assign bus.done = (state == S_DONE);

  assign beat_live = bus.in_valid && (state == S_RUN) && !bus.start;
  assign tuple_ok  = (bus.q_idx == exp_q) && (bus.n_idx == exp_n) && (bus.i_idx == exp_i);
  assign accept    = beat_live && tuple_ok;

  // Expected tuple walks q fastest, then n, then i.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      exp_q <= 4'd1;
      exp_n <= 8'd1;
      exp_i <= 4'd1;
    end else if (bus.start) begin
      exp_q <= 4'd1;
      exp_n <= 8'd1;
      exp_i <= 4'd1;
    end else if (accept) begin
      if (exp_q == Q_LAST) begin
        exp_q <= 4'd1;
        if (exp_n == N_LAST) begin
          exp_n <= 8'd1;
          exp_i <= exp_i + 4'd1;
        end else begin
          exp_n <= exp_n + 8'd1;
        end
      end else begin
        exp_q <= exp_q + 4'd1;
      end
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst)                       err_r <= 1'b0;
    else if (bus.start)             err_r <= 1'b0;
    else if (beat_live && !tuple_ok) err_r <= 1'b1;
  end
  assign bus.err = err_r;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      v1 <= 1'b0; q_first1 <= 1'b0; q_last1 <= 1'b0;
      n_first1 <= 1'b0; n_last1 <= 1'b0; i1 <= '0; p1 <= '0; w2_1 <= '0;
    end else begin
      v1 <= accept;
      if (accept) begin
        p1       <= PW'(bus.x_in) * PW'(bus.w1_in);
        q_first1 <= (bus.q_idx == 4'd1);
        q_last1  <= (bus.q_idx == Q_LAST);
        n_first1 <= (bus.n_idx == 8'd1);
        n_last1  <= (bus.n_idx == N_LAST);
        i1       <= bus.i_idx;
        if (bus.q_idx == Q_LAST) w2_1 <= bus.w2_in;
      end
    end
  end

  assign h_sum  = q_first1 ? HW'(p1) : hacc + HW'(p1);
  assign h_relu = h_sum[HW-1] ? '0 : h_sum;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      v2 <= 1'b0; hacc <= '0; h2 <= '0; w2_2 <= '0;
      n_first2 <= 1'b0; n_last2 <= 1'b0; i2 <= '0;
    end else begin
      v2 <= v1 && q_last1 && !bus.start;
      if (v1) begin
        hacc <= h_sum;
        if (q_last1) begin
          h2       <= h_relu;
          w2_2     <= w2_1;
          n_first2 <= n_first1;
          n_last2  <= n_last1;
          i2       <= i1;
        end
      end
    end
  end

  assign prod2 = OW'(h2) * OW'(w2_2);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      v3 <= 1'b0; sacc <= '0; i3 <= '0;
    end else begin
      v3 <= v2 && n_last2 && !bus.start;
      if (v2) begin
        sacc <= n_first2 ? prod2 : sacc + prod2;
        i3   <= i2;
      end
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      sv_r <= 1'b0; sidx_r <= '0; score_r <= '0;
    end else begin
      sv_r <= v3 && !bus.start;
      if (v3) begin
        score_r <= sacc;
        sidx_r  <= i3;
      end
    end
  end
  assign bus.score_valid = sv_r;
  assign bus.score_idx   = sidx_r;
  assign bus.score       = score_r;

  // Strict greater-than keeps the lowest class index on ties.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      max_idx <= '0; max_score <= '0;
    end else if (bus.start) begin
      max_idx <= '0; max_score <= '0;
    end else if (sv_r && state == S_RUN) begin
      if (sidx_r == 4'd1 || score_r > max_score) begin
        max_idx   <= sidx_r;
        max_score <= score_r;
      end
    end
  end
  assign bus.class_idx   = max_idx;
  assign bus.class_score = max_score;
endmodule

// File: tb/tb_mlp_mac_argmax.sv
// Directed bench for mlp_mac_argmax: table of full runs with hand-computed scores,
// plus reset-mid-run, start-abort flush and out-of-order beat sequences.
`timescale 1ns/1ps
module tb_mlp_mac_argmax;
  localparam int DW = 8, NQ = 8, NN = 200, NI = 10, OW = 36;

  logic clk = 1'b0;
  logic rst = 1'b0;
  always #5 clk = ~clk;

  mlp_mac_argmax_if #(.DW(DW), .OW(OW)) bus ();
  mlp_mac_argmax #(.DW(DW), .NQ(NQ), .NN(NN), .NI(NI), .OW(OW)) dut (
    .clk(clk), .rst(rst), .bus(bus)
  );

  typedef struct {
    string             name;
    logic signed [7:0] x;
    logic signed [7:0] w1;
    logic signed [7:0] w2;
    bit                w2_by_i;
    bit                skip;
    longint            unit;
    int                cls;
    longint            cscore;
  } run_t;

  run_t   tab [4];
  int     total = 0;
  int     bad   = 0;
  int     cyc   = 0;
  int     sv_cnt = 0;
  int     sv_idx [16];
  longint sv_score [16];
  int     sv_cyc [16];
  int     exp_cyc [11];

  always @(posedge clk) cyc <= cyc + 1;

  always @(negedge clk) begin
    if (bus.score_valid) begin
      if (sv_cnt < 16) begin
        sv_idx[sv_cnt]   = int'(bus.score_idx);
        sv_score[sv_cnt] = longint'(bus.score);
        sv_cyc[sv_cnt]   = cyc;
      end
      sv_cnt = sv_cnt + 1;
    end
  end

  task automatic check(input string nm, input longint act, input longint exp);
    total = total + 1;
    if (act != exp) begin
      bad = bad + 1;
      $display("FAIL %s: got %0d expected %0d", nm, act, exp);
    end
  endtask

  task automatic drive_beat(input int q, input int n, input int i, input run_t c);
    bus.in_valid = 1'b1;
    bus.q_idx    = 4'(q);
    bus.n_idx    = 8'(n);
    bus.i_idx    = 4'(i);
    bus.x_in     = c.x;
    bus.w1_in    = c.w1;
    if (c.w2_by_i) bus.w2_in = 8'(i);
    else           bus.w2_in = c.w2;
  endtask

  task automatic feed(input run_t c, input int limit);
    int cnt = 0;
    for (int i = 1; i <= NI; i++)
      for (int n = 1; n <= NN; n++)
        for (int q = 1; q <= NQ; q++) begin
          if (cnt >= limit) return;
          if (c.skip && q == 1 && n == 5 && i == 1) begin
            @(negedge clk);
            check("err_before_skip", longint'(bus.err), 0);
            drive_beat(1, 6, 1, c);
            @(negedge clk);
            check("err_after_skip", longint'(bus.err), 1);
            drive_beat(2, 5, 1, c);
          end
          @(negedge clk);
          drive_beat(q, n, i, c);
          if (q == NQ && n == NN) exp_cyc[i] = cyc + 4;
          cnt++;
        end
  endtask

  task automatic pulse_start();
    @(negedge clk);
    bus.in_valid = 1'b0;
    bus.start    = 1'b1;
    @(negedge clk);
    bus.start = 1'b0;
  endtask

  task automatic run_full(input run_t c);
    int w = 0;
    longint es;
    pulse_start();
    sv_cnt = 0;
    check({c.name, "_busy_at_start"}, longint'(bus.busy), 1);
    check({c.name, "_done_at_start"}, longint'(bus.done), 0);
    check({c.name, "_err_at_start"}, longint'(bus.err), 0);
    feed(c, 1 << 30);
    @(negedge clk);
    bus.in_valid = 1'b0;
    while (!bus.done && w < 40) begin
      @(negedge clk);
      w++;
    end
    check({c.name, "_done"}, longint'(bus.done), 1);
    check({c.name, "_busy_end"}, longint'(bus.busy), 0);
    check({c.name, "_pulses"}, sv_cnt, NI);
    for (int j = 0; j < NI && j < sv_cnt; j++) begin
      es = c.w2_by_i ? c.unit * (j + 1) : c.unit;
      check($sformatf("%s_idx%0d", c.name, j + 1), sv_idx[j], j + 1);
      check($sformatf("%s_score%0d", c.name, j + 1), sv_score[j], es);
      check($sformatf("%s_lat%0d", c.name, j + 1), sv_cyc[j], exp_cyc[j + 1]);
    end
    check({c.name, "_class_idx"}, longint'(bus.class_idx), c.cls);
    check({c.name, "_class_score"}, longint'(bus.class_score), c.cscore);
    check({c.name, "_err_end"}, longint'(bus.err), longint'(c.skip));
    drive_beat(1, 1, 1, c);
    @(negedge clk);
    bus.in_valid = 1'b0;
    @(negedge clk);
    check({c.name, "_post_done"}, longint'(bus.done), 1);
    check({c.name, "_post_err"}, longint'(bus.err), longint'(c.skip));
    check({c.name, "_post_pulses"}, sv_cnt, NI);
    check({c.name, "_post_class"}, longint'(bus.class_idx), c.cls);
  endtask

  initial begin
    #1500000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    bus.start = 1'b0; bus.in_valid = 1'b0;
    bus.q_idx = '0; bus.n_idx = '0; bus.i_idx = '0;
    bus.x_in = '0; bus.w1_in = '0; bus.w2_in = '0;

    tab[0] = '{"ones_skip", 8'sd1,    8'sd1,    8'sd1,   1'b0, 1'b1, 64'sd1600,       1,  64'sd1600};
    tab[1] = '{"relu_zero", 8'sd1,    -8'sd1,   8'sd1,   1'b0, 1'b0, 64'sd0,          1,  64'sd0};
    tab[2] = '{"w2_ramp",   8'sd1,    8'sd1,    8'sd0,   1'b1, 1'b0, 64'sd1600,       10, 64'sd16000};
    tab[3] = '{"extreme",   -8'sd128, -8'sd128, 8'sd127, 1'b0, 1'b0, 64'sd3329228800, 1,  64'sd3329228800};

    repeat (3) @(negedge clk);
    check("rst_busy", longint'(bus.busy), 0);
    check("rst_done", longint'(bus.done), 0);
    check("rst_err", longint'(bus.err), 0);
    check("rst_sv", longint'(bus.score_valid), 0);
    check("rst_score", longint'(bus.score), 0);
    check("rst_class_idx", longint'(bus.class_idx), 0);
    check("rst_class_score", longint'(bus.class_score), 0);

    rst = 1'b1;
    @(negedge clk);
    drive_beat(1, 1, 1, tab[0]);
    @(negedge clk);
    bus.in_valid = 1'b0;
    check("idle_beat_busy", longint'(bus.busy), 0);
    check("idle_beat_err", longint'(bus.err), 0);

    // Reset in the middle of a run, with err already raised by a skipped beat.
    pulse_start();
    feed(tab[0], 500);
    check("pre_rst_busy", longint'(bus.busy), 1);
    check("pre_rst_err", longint'(bus.err), 1);
    #1;
    rst = 1'b0;
    #1;
    check("mid_rst_busy", longint'(bus.busy), 0);
    check("mid_rst_err", longint'(bus.err), 0);
    check("mid_rst_done", longint'(bus.done), 0);
    @(negedge clk);
    bus.in_valid = 1'b0;
    rst = 1'b1;

    // Abort right after the first score's last beat; no stale pulse may follow.
    pulse_start();
    feed(tab[2], NQ * NN);

    for (int r = 0; r < 4; r++) run_full(tab[r]);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
